// File: rtl/aes_pkg.sv
// Shared AES-128 types, the forward S-box, and the key-schedule round constants.
// No clocked logic lives here.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;
  typedef logic [7:0]   byte_t;

  localparam byte_t RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Row r of the literal holds S-box entries 16r..16r+15; element 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic word_t sub_word(input word_t w);
    word_t r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = SBOX[w[8*i +: 8]];
    end
    return r;
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: derives round key r+1 from round key r and rcon.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Column 0 sits in [127:96]; each column is chained from the one before it.
module aes_key_step
  import aes_pkg::*;
(
  input  state_t cur_key,
  input  byte_t  rcon,
  output state_t next_key
);

  word_t w0, w1, w2, w3;
  word_t n0, n1, n2, n3;
  word_t temp;

  assign {w0, w1, w2, w3} = cur_key;

  assign temp = sub_word(rot_word(w3)) ^ {rcon, 24'h000000};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round_key_add.sv
// Registered AddRoundKey stage with on-the-fly AES-128 key schedule; AES_RK_LAST_FLAG_EN adds out_last.
// Latency: 1 cycle accept-to-out_valid, one beat per cycle while out_ready is high.
// Backpressure: in_ready drops while out_valid && !out_ready; held output and schedule freeze.
module aes_round_key_add
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  state_t       key_in,
  output logic         key_loaded,
  input  logic         in_valid,
  output logic         in_ready,
  input  state_t       state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output state_t       state_out,
  output logic [3:0]   round_out
`ifdef AES_RK_LAST_FLAG_EN
  ,
  output logic         out_last
`endif
);

  state_t     cipher_key_q, cipher_key_d;
  state_t     cur_key_q,    cur_key_d;
  logic [3:0] round_cnt_q,  round_cnt_d;
  logic       key_loaded_q, key_loaded_d;
  logic       out_valid_q,  out_valid_d;
  state_t     state_out_q,  state_out_d;
  logic [3:0] round_out_q,  round_out_d;
  logic       out_last_q,   out_last_d;

  logic       accept;
  logic       last_round;
  logic [3:0] rcon_idx;
  state_t     next_key;

  assign in_ready   = key_loaded_q && !key_load && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign last_round = (round_cnt_q == 4'(NUM_ROUNDS));

  // The index is only consumed when the counter advances; park it on 1 at the wrap.
  assign rcon_idx = last_round ? 4'd1 : round_cnt_q + 4'd1;

  aes_key_step u_key_step (
    .cur_key  (cur_key_q),
    .rcon     (RCON[rcon_idx]),
    .next_key (next_key)
  );

  always_comb begin
    cipher_key_d = cipher_key_q;
    cur_key_d    = cur_key_q;
    round_cnt_d  = round_cnt_q;
    key_loaded_d = key_loaded_q;
    out_valid_d  = out_valid_q;
    state_out_d  = state_out_q;
    round_out_d  = round_out_q;
    out_last_d   = out_last_q;

    if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (key_load) begin
      cipher_key_d = key_in;
      cur_key_d    = key_in;
      round_cnt_d  = 4'd0;
      key_loaded_d = 1'b1;
    end else if (accept) begin
      state_out_d = state_in ^ cur_key_q;
      round_out_d = round_cnt_q;
      out_last_d  = last_round;
      // Wrapping back to the cipher key lets the next block start without a reload.
      if (last_round) begin
        cur_key_d   = cipher_key_q;
        round_cnt_d = 4'd0;
      end else begin
        cur_key_d   = next_key;
        round_cnt_d = round_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cipher_key_q <= '0;
      cur_key_q    <= '0;
      round_cnt_q  <= '0;
      key_loaded_q <= 1'b0;
      out_valid_q  <= 1'b0;
      state_out_q  <= '0;
      round_out_q  <= '0;
      out_last_q   <= 1'b0;
    end else begin
      cipher_key_q <= cipher_key_d;
      cur_key_q    <= cur_key_d;
      round_cnt_q  <= round_cnt_d;
      key_loaded_q <= key_loaded_d;
      out_valid_q  <= out_valid_d;
      state_out_q  <= state_out_d;
      round_out_q  <= round_out_d;
      out_last_q   <= out_last_d;
    end
  end

  assign key_loaded = key_loaded_q;
  assign out_valid  = out_valid_q;
  assign state_out  = state_out_q;
  assign round_out  = round_out_q;
`ifdef AES_RK_LAST_FLAG_EN
  assign out_last   = out_last_q;
`else
  logic unused_last;
  assign unused_last = out_last_q;
`endif

endmodule
